segbuf_rx: RTL and testbench

SEGBUF_RX -- requirements
Module: segbuf_rx

---
 rtl/segbuf_pkg.sv | 26 ++
 rtl/segbuf_csum.sv | 37 +++
 rtl/segbuf_rx.sv | 179 +++++++++++++++++
 tb/tb_segbuf_rx.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segbuf_pkg.sv
// Shared definitions for the segmented-buffer link: control symbols,
// segment size, receive state encoding and the checksum rule. Any
// transmitter for this link imports this package so both ends agree.
package segbuf_pkg;

  localparam logic [7:0]  K_START   = 8'h5C;  // frame start (K28.2)
  localparam logic [7:0]  K_STOP    = 8'h3C;  // end of payload (K28.1)
  localparam logic [7:0]  K_COMMA   = 8'hBC;  // idle comma (K28.5)
  localparam int unsigned SEG_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CSUM_HI = 3'd4,
    CSUM_LO = 3'd5
  } seg_state_e;

  // Transmitted checksum word is the ones-complement-style residue of the
  // 16-bit byte sum, so a frame is good when the received word equals it.
  function automatic logic [15:0] csum_expect(input logic [15:0] sum);
    return 16'hFFFF - sum;
  endfunction

endpackage

// File: rtl/segbuf_csum.sv
// Segment checksum accumulator.
// Ports:
//   clk        - receive clock
//   reset      - synchronous active-high reset, clears the sum
//   clear      - load the sum with data (address byte starts a new frame)
//   accumulate - add data to the running sum (payload bytes)
//   data       - byte being loaded or added
//   rx_word    - received checksum word {hi,lo}
//   match      - rx_word equals 16'hFFFF - sum
module segbuf_csum
  import segbuf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accumulate,
  input  logic [7:0]  data,
  input  logic [15:0] rx_word,
  output logic        match
);

  logic [15:0] sum;

  // Running 16-bit byte sum; clear has priority over accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= 16'h0000;
    end else if (clear) begin
      sum <= {8'h00, data};
    end else if (accumulate) begin
      sum <= sum + {8'h00, data};
    end
  end

  assign match = (rx_word == csum_expect(sum));

endmodule

// File: rtl/segbuf_rx.sv
// Receive side of the segmented-buffer link on a 16-bit GTP word.
// The event lane ([15:8]) carries event codes every cycle; the data lane
// ([7:0]) alternates segment slots and distributed-bus slots.
// Ports:
//   rx_clk, reset            - receive clock, synchronous active-high reset
//   rx_data, rxcharisk       - GTP word and per-lane K flags
//   aligned                  - comma alignment; stream invalid when low
//   ev_valid, ev_code        - event code pulse
//   dbus_valid, dbus         - distributed-bus byte from a dbus slot
//   seg_valid, seg_addr,
//   seg_data                 - completed good segment (held until next one)
//   seg_err, err_cnt         - aborted/bad frame pulse and saturating count
module segbuf_rx
  import segbuf_pkg::*;
(
  input  logic         rx_clk,
  input  logic         reset,
  input  logic [15:0]  rx_data,
  input  logic [1:0]   rxcharisk,
  input  logic         aligned,
  output logic         ev_valid,
  output logic [7:0]   ev_code,
  output logic         dbus_valid,
  output logic [7:0]   dbus,
  output logic         seg_valid,
  output logic [7:0]   seg_addr,
  output logic [127:0] seg_data,
  output logic         seg_err,
  output logic [15:0]  err_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(SEG_BYTES - 1);

  seg_state_e   state;
  logic         seg_slot;      // current cycle is a segment slot
  logic         phase_locked;
  logic [3:0]   byte_idx;
  logic [7:0]   frame_addr;
  logic [127:0] frame_buf;     // shadow payload, published only on a good frame
  logic [7:0]   csum_hi;

  logic [7:0]   data_byte;
  logic         data_k;
  logic         is_start;
  logic         ev_hit;
  logic         dbus_hit;
  logic         err_now;
  logic         good_now;
  logic         csum_clear;
  logic         csum_acc;
  logic         csum_match;

  assign data_byte = rx_data[7:0];
  assign data_k    = rxcharisk[0];
  // A start symbol resynchronises the slot phase wherever it lands.
  assign is_start  = aligned & data_k & (data_byte == K_START);
  assign ev_hit    = aligned & ~rxcharisk[1] & (rx_data[15:8] != 8'h00);
  assign dbus_hit  = aligned & phase_locked & ~is_start & ~seg_slot;

  segbuf_csum u_csum (
    .clk        (rx_clk),
    .reset      (reset),
    .clear      (csum_clear),
    .accumulate (csum_acc),
    .data       (data_byte),
    .rx_word    ({csum_hi, data_byte}),
    .match      (csum_match)
  );

  // Frame outcome and checksum control for the current segment slot.
  always_comb begin
    err_now    = 1'b0;
    good_now   = 1'b0;
    csum_clear = 1'b0;
    csum_acc   = 1'b0;
    if (!aligned || is_start) begin
      // Loss of alignment or a restart abandons any frame in progress.
      err_now = (state != IDLE);
    end else if (seg_slot) begin
      case (state)
        IDLE:    err_now = 1'b0;
        ADDR:    begin
                   err_now    = data_k;
                   csum_clear = ~data_k;
                 end
        DATA:    begin
                   err_now  = data_k;
                   csum_acc = ~data_k;
                 end
        STOP:    err_now = ~(data_k && (data_byte == K_STOP));
        CSUM_HI: err_now = data_k;
        CSUM_LO: begin
                   good_now = ~data_k & csum_match;
                   err_now  = data_k | ~csum_match;
                 end
        default: err_now = 1'b0;
      endcase
    end else begin
      err_now = 1'b0;
    end
  end

  // Receive FSM, slot phase tracking and all registered outputs.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state        <= IDLE;
      seg_slot     <= 1'b0;
      phase_locked <= 1'b0;
      byte_idx     <= 4'd0;
      frame_addr   <= 8'h00;
      frame_buf    <= 128'h0;
      csum_hi      <= 8'h00;
      ev_valid     <= 1'b0;
      ev_code      <= 8'h00;
      dbus_valid   <= 1'b0;
      dbus         <= 8'h00;
      seg_valid    <= 1'b0;
      seg_addr     <= 8'h00;
      seg_data     <= 128'h0;
      seg_err      <= 1'b0;
      err_cnt      <= 16'h0000;
    end else begin
      ev_valid <= ev_hit;
      if (ev_hit) ev_code <= rx_data[15:8];
      dbus_valid <= dbus_hit;
      if (dbus_hit) dbus <= data_byte;
      seg_valid <= good_now;
      seg_err   <= err_now;
      if (err_now && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
      if (good_now) begin
        seg_addr <= frame_addr;
        seg_data <= frame_buf;
      end

      // The start symbol occupies a segment slot, so the next is a dbus slot.
      seg_slot <= is_start ? 1'b0 : ~seg_slot;

      if (!aligned) begin
        phase_locked <= 1'b0;
      end else if (is_start) begin
        phase_locked <= 1'b1;
      end

      if (!aligned) begin
        state <= IDLE;
      end else if (is_start) begin
        state <= ADDR;
      end else if (seg_slot) begin
        case (state)
          IDLE:    state <= IDLE;
          ADDR:    if (data_k) begin
                     state <= IDLE;
                   end else begin
                     frame_addr <= data_byte;
                     byte_idx   <= 4'd0;
                     state      <= DATA;
                   end
          DATA:    if (data_k) begin
                     state <= IDLE;
                   end else begin
                     frame_buf[{byte_idx, 3'b000} +: 8] <= data_byte;
                     byte_idx <= byte_idx + 4'd1;
                     if (byte_idx == LAST_IDX) state <= STOP;
                   end
          STOP:    state <= err_now ? IDLE : CSUM_HI;
          CSUM_HI: if (data_k) begin
                     state <= IDLE;
                   end else begin
                     csum_hi <= data_byte;
                     state   <= CSUM_LO;
                   end
          CSUM_LO: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segbuf_rx.sv
// Self-checking bench for segbuf_rx: directed frames from the reference
// vectors, event/dbus lane behaviour, alignment loss, restart, reset and
// counter saturation, plus randomized frames checked against frame-level
// expectations computed by the bench.
module tb_segbuf_rx;
  import segbuf_pkg::*;

  logic         rx_clk = 1'b0;
  logic         reset;
  logic [15:0]  rx_data;
  logic [1:0]   rxcharisk;
  logic         aligned;
  logic         ev_valid;
  logic [7:0]   ev_code;
  logic         dbus_valid;
  logic [7:0]   dbus;
  logic         seg_valid;
  logic [7:0]   seg_addr;
  logic [127:0] seg_data;
  logic         seg_err;
  logic [15:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]   fb [0:20];
  logic         fk [0:20];
  logic [7:0]   exp_addr;
  logic [127:0] exp_data;
  logic [15:0]  exp_cnt;
  logic         locked;

  localparam logic [127:0] D034 = 128'h07000000_00000000_07000000_7BFC8B00;
  localparam logic [127:0] D035 = {64'hAD74347A74AD74AD, 64'hAD74347A74AD74AD};

  always #5 rx_clk = ~rx_clk;

  segbuf_rx dut (
    .rx_clk(rx_clk), .reset(reset), .rx_data(rx_data), .rxcharisk(rxcharisk),
    .aligned(aligned), .ev_valid(ev_valid), .ev_code(ev_code),
    .dbus_valid(dbus_valid), .dbus(dbus), .seg_valid(seg_valid),
    .seg_addr(seg_addr), .seg_data(seg_data), .seg_err(seg_err), .err_cnt(err_cnt)
  );

  function automatic logic [15:0] ref_csum(input logic [7:0] a, input logic [127:0] d);
    int s;
    s = int'(a);
    for (int k = 0; k < 16; k++) s += int'(d[8*k +: 8]);
    s = 65535 - s;
    return s[15:0];
  endfunction

  task automatic build_frame(input logic [7:0] a, input logic [127:0] d, input logic [15:0] c);
    fb[0] = K_START; fk[0] = 1'b1;
    fb[1] = a;       fk[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      fb[2+k] = d[8*k +: 8]; fk[2+k] = 1'b0;
    end
    fb[18] = K_STOP;   fk[18] = 1'b1;
    fb[19] = c[15:8];  fk[19] = 1'b0;
    fb[20] = c[7:0];   fk[20] = 1'b0;
  endtask

  task automatic step(input logic [7:0] ev, input logic evk, input logic [7:0] d,
                      input logic dk, input logic al);
    @(negedge rx_clk);
    rx_data   = {ev, d};
    rxcharisk = {evk, dk};
    aligned   = al;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    total++;
    if ({ev_valid, ev_code, dbus_valid, dbus, seg_valid, seg_addr, seg_err, err_cnt} !== 44'h0) begin
      bad++; $display("FAIL reset_outputs: got %h expected 0",
                      {ev_valid, ev_code, dbus_valid, dbus, seg_valid, seg_addr, seg_err, err_cnt});
    end
    total++;
    if (seg_data !== 128'h0) begin bad++; $display("FAIL reset_seg_data: got %h expected 0", seg_data); end
    reset = 1'b0;
    exp_addr = 8'h00; exp_data = 128'h0; exp_cnt = 16'h0; locked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b0, 8'($urandom), 1'b0, 1'b1);
      total++;
      if ({dbus_valid, seg_valid, seg_err} !== 3'b000) begin
        bad++; $display("FAIL unlocked_idle: got %b expected 000", {dbus_valid, seg_valid, seg_err});
      end
    end
  endtask

  task automatic test_frame_034;
    build_frame(8'hFF, D034, 16'hFCF0);
    for (int i = 0; i < 21; i++) begin
      step(8'h00, 1'b0, fb[i], fk[i], 1'b1);
      total++;
      if ({seg_valid, seg_err} !== {(i == 20), 1'b0}) begin
        bad++; $display("FAIL f034_pulse[%0d]: got %b expected %b", i, {seg_valid, seg_err}, {(i == 20), 1'b0});
      end
      step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    exp_addr = 8'hFF; exp_data = D034;
    total++;
    if (seg_addr !== 8'hFF) begin bad++; $display("FAIL f034_addr: got %h expected ff", seg_addr); end
    total++;
    if (seg_data[31:0] !== 32'h7BFC8B00) begin
      bad++; $display("FAIL f034_data_lo: got %h expected 7bfc8b00", seg_data[31:0]);
    end
    total++;
    if (seg_data !== D034) begin bad++; $display("FAIL f034_data: got %h expected %h", seg_data, D034); end
  endtask

  task automatic test_frame_035;
    for (int pass = 0; pass < 2; pass++) begin
      build_frame(8'h04, D035, (pass == 0) ? 16'hF7D9 : 16'hF7D8);
      for (int i = 0; i < 21; i++) begin
        step(8'h00, 1'b0, fb[i], fk[i], 1'b1);
        total++;
        if ({seg_valid, seg_err} !== {(i == 20 && pass == 0), (i == 20 && pass == 1)}) begin
          bad++; $display("FAIL f035_pulse[%0d,%0d]: got %b", pass, i, {seg_valid, seg_err});
        end
        step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      end
    end
    exp_addr = 8'h04; exp_data = D035; exp_cnt = exp_cnt + 16'd1;
    total++;
    if (seg_addr !== 8'h04) begin bad++; $display("FAIL f035_addr: got %h expected 04", seg_addr); end
    total++;
    if (seg_data !== D035) begin bad++; $display("FAIL f035_data_kept: got %h expected %h", seg_data, D035); end
    total++;
    if (err_cnt !== 16'd1) begin bad++; $display("FAIL f035_err_cnt: got %0d expected 1", err_cnt); end
  endtask

  task automatic test_events_dbus;
    logic [7:0] evb, db;
    logic       evk;
    int         c = 0;
    build_frame(8'hFF, D034, 16'hFCF0);
    for (int i = 0; i < 21; i++) begin
      for (int half = 0; half < 2; half++) begin
        evk = (c % 4 == 0);
        evb = (c % 4 == 0) ? K_COMMA : ((c % 4 == 2) ? 8'h7E : 8'h00);
        db  = (i % 2 == 0) ? 8'hA5 : 8'h00;
        if (half == 0) step(evb, evk, fb[i], fk[i], 1'b1);
        else           step(evb, evk, db, 1'b0, 1'b1);
        total++;
        if (ev_valid !== (c % 4 == 2)) begin
          bad++; $display("FAIL ev_valid[%0d]: got %b expected %b", c, ev_valid, (c % 4 == 2));
        end
        if (c % 4 == 2) begin
          total++;
          if (ev_code !== 8'h7E) begin bad++; $display("FAIL ev_code[%0d]: got %h expected 7e", c, ev_code); end
        end
        total++;
        if (dbus_valid !== (half == 1)) begin
          bad++; $display("FAIL dbus_valid[%0d]: got %b expected %b", c, dbus_valid, (half == 1));
        end
        if (half == 1) begin
          total++;
          if (dbus !== db) begin bad++; $display("FAIL dbus[%0d]: got %h expected %h", c, dbus, db); end
        end else begin
          total++;
          if (seg_valid !== (i == 20)) begin
            bad++; $display("FAIL ev_frame_valid[%0d]: got %b expected %b", i, seg_valid, (i == 20));
          end
        end
        c++;
      end
    end
    exp_addr = 8'hFF; exp_data = D034;
  endtask

  task automatic test_align_drop;
    logic [7:0]   a;
    logic [127:0] d;
    a = 8'h21; d = {$urandom, $urandom, $urandom, $urandom};
    build_frame(a, d, ref_csum(a, d));
    for (int i = 0; i < 8; i++) begin
      step(8'h00, 1'b0, fb[i], fk[i], 1'b1);
      step(8'h00, 1'b0, 8'h5A, 1'b0, 1'b1);
    end
    total++;
    if ({dbus_valid, dbus} !== {1'b1, 8'h5A}) begin
      bad++; $display("FAIL ad_dbus_before: got %b/%h expected 1/5a", dbus_valid, dbus);
    end
    step(8'h00, 1'b0, fb[8], fk[8], 1'b0);
    locked = 1'b0; exp_cnt = exp_cnt + 16'd1;
    total++;
    if ({seg_err, seg_valid, dbus_valid} !== 3'b100) begin
      bad++; $display("FAIL ad_drop_err: got %b expected 100", {seg_err, seg_valid, dbus_valid});
    end
    for (int k = 0; k < 10; k++) begin
      step(8'h00, 1'b0, 8'($urandom), 1'b0, (k >= 3));
      total++;
      if ({seg_err, seg_valid, dbus_valid} !== 3'b000) begin
        bad++; $display("FAIL ad_after[%0d]: got %b expected 000", k, {seg_err, seg_valid, dbus_valid});
      end
    end
    total++;
    if (err_cnt !== exp_cnt) begin bad++; $display("FAIL ad_err_cnt: got %0d expected %0d", err_cnt, exp_cnt); end
    for (int i = 0; i < 21; i++) begin
      step(8'h00, 1'b0, fb[i], fk[i], 1'b1);
      total++;
      if (seg_valid !== (i == 20)) begin bad++; $display("FAIL ad_refrm[%0d]: got %b", i, seg_valid); end
      step(8'h00, 1'b0, 8'h33, 1'b0, 1'b1);
      total++;
      if (dbus_valid !== 1'b1) begin bad++; $display("FAIL ad_relock[%0d]: got %b expected 1", i, dbus_valid); end
    end
    locked = 1'b1; exp_addr = a; exp_data = d;
    total++;
    if ({seg_addr, seg_data} !== {a, d}) begin bad++; $display("FAIL ad_refrm_data: got %h expected %h", {seg_addr, seg_data}, {a, d}); end
  endtask

  task automatic test_restart;
    logic [7:0]   a;
    logic [127:0] d;
    a = 8'($urandom); d = {$urandom, $urandom, $urandom, $urandom};
    build_frame(a, d, ref_csum(a, d));
    for (int i = 0; i < 11; i++) begin
      step(8'h00, 1'b0, fb[i], fk[i], 1'b1);
      step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    a = 8'($urandom); d = {$urandom, $urandom, $urandom, $urandom};
    build_frame(a, d, ref_csum(a, d));
    for (int i = 0; i < 21; i++) begin
      step(8'h00, 1'b0, fb[i], fk[i], 1'b1);
      total++;
      if ({seg_valid, seg_err} !== {(i == 20), (i == 0)}) begin
        bad++; $display("FAIL rs_pulse[%0d]: got %b expected %b", i, {seg_valid, seg_err}, {(i == 20), (i == 0)});
      end
      step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    exp_addr = a; exp_data = d; exp_cnt = exp_cnt + 16'd1;
    total++;
    if ({seg_addr, seg_data, err_cnt} !== {exp_addr, exp_data, exp_cnt}) begin
      bad++; $display("FAIL rs_result: got %h expected %h", {seg_addr, seg_data, err_cnt}, {exp_addr, exp_data, exp_cnt});
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0]   a;
    logic [127:0] d;
    a = 8'($urandom); d = {$urandom, $urandom, $urandom, $urandom};
    build_frame(a, d, ref_csum(a, d));
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 1'b0, fb[i], fk[i], 1'b1);
      step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    reset = 1'b1;
    step(8'h00, 1'b0, fb[5], fk[5], 1'b1);
    step(8'h00, 1'b0, fb[6], fk[6], 1'b1);
    reset = 1'b0;
    exp_addr = 8'h00; exp_data = 128'h0; exp_cnt = 16'h0; locked = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(8'h00, 1'b0, (k < 4) ? fb[7+k] : 8'($urandom), 1'b0, 1'b1);
      total++;
      if ({ev_valid, ev_code, dbus_valid, dbus, seg_valid, seg_addr, seg_data, seg_err, err_cnt} !== 172'h0) begin
        bad++; $display("FAIL rm_zero[%0d]: got %h expected 0",
                        k, {ev_valid, ev_code, dbus_valid, dbus, seg_valid, seg_addr, seg_data, seg_err, err_cnt});
      end
    end
  endtask

  task automatic test_random_frames;
    logic [7:0]   a, ev, db;
    logic [127:0] d;
    logic         evk, e_err, e_val;
    int           mode, p, g;
    for (int f = 0; f < 30; f++) begin
      a = 8'($urandom); d = {$urandom, $urandom, $urandom, $urandom};
      build_frame(a, d, ref_csum(a, d));
      mode = $urandom_range(0, 4);
      p    = $urandom_range(1, 20);
      if (mode == 2)      fb[20] = fb[20] ^ 8'($urandom_range(1, 255));
      else if (mode == 3) begin fb[p] = 8'h1C; fk[p] = 1'b1; end
      else if (mode == 4) fk[18] = 1'b0;
      g = $urandom_range(0, 3);
      for (int i = -g; i < 21; i++) begin
        ev = 8'($urandom); evk = 1'($urandom);
        if (i < 0) step(ev, evk, 8'($urandom), 1'b0, 1'b1);
        else       step(ev, evk, fb[i], fk[i], 1'b1);
        if (i == 0) locked = 1'b1;
        e_err = (i == 20 && mode == 2) || (i == p && mode == 3) || (i == 18 && mode == 4);
        e_val = (i == 20 && mode < 2);
        total++;
        if ({seg_valid, seg_err, dbus_valid} !== {e_val, e_err, 1'b0}) begin
          bad++; $display("FAIL rnd_seg[%0d,%0d] mode %0d: got %b expected %b",
                          f, i, mode, {seg_valid, seg_err, dbus_valid}, {e_val, e_err, 1'b0});
        end
        total++;
        if (ev_valid !== (!evk && ev != 8'h00) || (ev_valid && ev_code !== ev)) begin
          bad++; $display("FAIL rnd_ev[%0d,%0d]: got %b/%h sent %b/%h", f, i, ev_valid, ev_code, evk, ev);
        end
        ev = 8'($urandom); evk = 1'($urandom); db = 8'($urandom);
        step(ev, evk, db, 1'b0, 1'b1);
        total++;
        if ({dbus_valid, seg_valid, seg_err} !== {locked, 2'b00} || (locked && dbus !== db)) begin
          bad++; $display("FAIL rnd_dbus[%0d,%0d]: got %b/%h expected %b/%h",
                          f, i, dbus_valid, dbus, locked, db);
        end
        total++;
        if (ev_valid !== (!evk && ev != 8'h00) || (ev_valid && ev_code !== ev)) begin
          bad++; $display("FAIL rnd_ev2[%0d,%0d]: got %b/%h sent %b/%h", f, i, ev_valid, ev_code, evk, ev);
        end
      end
      if (mode < 2) begin exp_addr = a; exp_data = d; end
      else exp_cnt = exp_cnt + 16'd1;
      total++;
      if ({seg_addr, seg_data, err_cnt} !== {exp_addr, exp_data, exp_cnt}) begin
        bad++; $display("FAIL rnd_result[%0d]: got %h expected %h",
                        f, {seg_addr, seg_data, err_cnt}, {exp_addr, exp_data, exp_cnt});
      end
    end
  endtask

  task automatic test_err_saturation;
    reset = 1'b1;
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    reset = 1'b0;
    // Back-to-back start symbols: every one after the first aborts a frame.
    for (int n = 1; n <= 65538; n++) begin
      step(8'h00, 1'b0, K_START, 1'b1, 1'b1);
      if (n == 2) begin
        total++;
        if (err_cnt !== 16'd1) begin bad++; $display("FAIL sat_first: got %0d expected 1", err_cnt); end
      end
      if (n == 65535) begin
        total++;
        if (err_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe: got %h expected fffe", err_cnt); end
      end
      if (n >= 65536) begin
        total++;
        if ({seg_err, err_cnt} !== {1'b1, 16'hFFFF}) begin
          bad++; $display("FAIL sat_hold[%0d]: got %b/%h expected 1/ffff", n, seg_err, err_cnt);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rx_data = 16'h0000; rxcharisk = 2'b00; aligned = 1'b0;
    test_reset();
    test_frame_034();
    test_frame_035();
    test_events_dbus();
    test_align_drop();
    test_restart();
    test_reset_midframe();
    test_random_frames();
    test_err_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
